alu: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_comb.sv | 49 ++++
 rtl/alu.sv | 42 ++++
 tb/tb_alu.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the lab-datapath ALU: the operation encoding and the
// default operand width.
// Build option: define ALU_SAT_EN for saturating ADD/SUB (default build wraps).
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Combinational core of the ALU: computes the result of one operation on two
// unsigned operands. No state.
// Build option: ALU_SAT_EN makes ADD clamp to all-ones on overflow and SUB
// clamp to zero on underflow; without it both wrap modulo 2^WIDTH.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;

`ifdef ALU_SAT_EN
  // One extra bit holds the carry out of ADD and the borrow out of SUB.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign add_res  = sum_ext[WIDTH]  ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
  assign sub_res  = diff_ext[WIDTH] ? {WIDTH{1'b0}} : diff_ext[WIDTH-1:0];
`else
  // Operands and results share a width, so the carry/borrow drops off and
  // the arithmetic wraps silently.
  assign add_res = a + b;
  assign sub_res = a - b;
`endif

  // Select the result for the requested operation.
  always_comb begin
    // NOTE: assign a default before the case so every path drives y;
    // a missed path would otherwise infer a latch.
    y = '0;
    case (op)
      ALU_ADD: y = add_res;
      ALU_SUB: y = sub_res;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule : alu_comb

// File: rtl/alu.sv
// Registered ALU for the lab datapath: one operation per clock, result and
// valid flag registered with latency 1. Free-running, no input handshake.
// Build option: ALU_SAT_EN (saturating ADD/SUB, see alu_comb).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] result;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .op(alu_op_e'(op_in)),
    .a (a_in),
    .b (b_in),
    .y (result)
  );

  // Output register: capture a new result every cycle out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= result;
      out_valid <= 1'b1;
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with hand-computed results.
// The stimulus process pushes the expected registered output for each edge
// into a scoreboard queue; an independent monitor pops and compares after
// every rising edge. Build option ALU_SAT_EN selects the saturating values.
module tb_alu;

  localparam int W = 4;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] out;
    logic         valid;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] out;
  logic         out_valid;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  alu #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_in    (op_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, record the output expected after the next
  // rising edge, then move to the following falling edge.
  task automatic step(input string name, input logic r, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e_out, input logic e_valid);
    exp_t e;
    rst   = r;
    op_in = op;
    a_in  = a;
    b_in  = b;
    e.out   = e_out;
    e.valid = e_valid;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_out"}, out, e.out);
        check({n, "_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, e.valid});
      end
    end
  end

  // Stimulus.
  initial begin
    int drain;
    // Reset for two edges; inputs are ignored.
    step("rst1", 1'b1, 2'b00, 4'd5, 4'd5, 4'd0, 1'b0);
    step("rst2", 1'b1, 2'b11, 4'd15, 4'd15, 4'd0, 1'b0);
    // First edge after release is valid.
    step("first_add", 1'b0, 2'b00, 4'd3, 4'd4, 4'd7, 1'b1);
    step("sub_9_6", 1'b0, 2'b01, 4'd9, 4'd6, 4'd3, 1'b1);
    step("sub_uflow", 1'b0, 2'b01, 4'd1, 4'd3, SAT ? 4'd0 : 4'd14, 1'b1);
    step("and_0_1", 1'b0, 2'b10, 4'd0, 4'd1, 4'd0, 1'b1);
    step("or_0_1", 1'b0, 2'b11, 4'd0, 4'd1, 4'd1, 1'b1);
    step("add_oflow", 1'b0, 2'b00, 4'd15, 4'd2, SAT ? 4'd15 : 4'd1, 1'b1);
    // Back-to-back: a new operation every cycle.
    step("b2b_add", 1'b0, 2'b00, 4'd6, 4'd7, 4'd13, 1'b1);
    step("b2b_sub", 1'b0, 2'b01, 4'd12, 4'd5, 4'd7, 1'b1);
    step("b2b_and", 1'b0, 2'b10, 4'd12, 4'd10, 4'd8, 1'b1);
    step("b2b_or", 1'b0, 2'b11, 4'd12, 4'd3, 4'd15, 1'b1);
    step("b2b_add_8_8", 1'b0, 2'b00, 4'd8, 4'd8, SAT ? 4'd15 : 4'd0, 1'b1);
    step("b2b_sub_eq", 1'b0, 2'b01, 4'd5, 4'd5, 4'd0, 1'b1);
    step("b2b_and_15_9", 1'b0, 2'b10, 4'd15, 4'd9, 4'd9, 1'b1);
    step("b2b_or_5_10", 1'b0, 2'b11, 4'd5, 4'd10, 4'd15, 1'b1);
    step("b2b_sub_0_1", 1'b0, 2'b01, 4'd0, 4'd1, SAT ? 4'd0 : 4'd15, 1'b1);
    step("b2b_add_15_0", 1'b0, 2'b00, 4'd15, 4'd0, 4'd15, 1'b1);
    // Mid-stream reset for one edge, then recovery.
    step("mid_rst", 1'b1, 2'b11, 4'd15, 4'd15, 4'd0, 1'b0);
    step("recover", 1'b0, 2'b00, 4'd2, 4'd3, 4'd5, 1'b1);
    step("recover_sub", 1'b0, 2'b01, 4'd14, 4'd4, 4'd10, 1'b1);
    step("recover_and", 1'b0, 2'b10, 4'd7, 4'd13, 4'd5, 1'b1);

    // Let the monitor drain the scoreboard, with a bounded wait.
    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(negedge clk);
      drain++;
    end
    check("scoreboard_empty", exp_q.size() > 0 ? 4'd1 : 4'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu
